fm0_frame_ctrl: RTL and testbench
=================================

FM0_FRAME_CTRL -- requirements
Module: fm0_frame_ctrl

Interface
REQ-001 SHALL have parameter TRACEBACK_DEPTH, default 5, bits per decoder output chunk.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of frame bit count.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-symbol watchdog limit in RUN.
REQ-004 SHALL have ports: clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: start in 1, frame-start pulse; frame_len in LEN_WIDTH, bits expected, sampled on accepted start.
REQ-006 SHALL have ports: corr_vld_in in 1, correlator symbol strobe; dec_vld out 1, gated strobe to decoder; dec_rst out 1, decoder metric clear.
REQ-007 SHALL have ports: dec_dat in TRACEBACK_DEPTH, decoded chunk; dec_out_vld in 1, chunk strobe.
REQ-008 SHALL have ports: bit_dat out 1, bit_vld out 1, bit_rdy in 1, serial bit stream with valid/ready.
REQ-009 SHALL have ports: busy out 1, done out 1 (pulse), err_timeout out 1, err_overflow out 1.

Function
REQ-010 SHALL implement FSM IDLE, CLEAR, RUN, DONE.
REQ-011 IDLE: start=1 SHALL latch frame_len and enter CLEAR next cycle; start ignored in all other states.
REQ-012 CLEAR SHALL last exactly 1 cycle with dec_rst=1, then enter RUN; if latched length is 0, SHALL enter DONE instead.
REQ-013 dec_vld SHALL equal corr_vld_in combinationally in RUN only; 0 elsewhere.
REQ-014 Chunk buffer SHALL be 2 entries (active shift register + pending); chunk accepted on dec_out_vld in RUN only.
REQ-015 Bits SHALL be emitted dec_dat[0] first; first bit_vld 1 cycle after chunk acceptance into empty buffer.
REQ-016 A bit SHALL transfer when bit_vld and bit_rdy high in the same cycle; bit_dat/bit_vld SHALL hold stable while bit_rdy=0.
REQ-017 Simultaneous last-bit transfer of active chunk and new chunk arrival SHALL NOT count as overflow.
REQ-018 Chunk arriving with both entries full SHALL be dropped, set err_overflow sticky until next accepted start.
REQ-019 Bit counter SHALL count transfers; when it reaches latched length, SHALL enter DONE same cycle-edge, discarding remaining buffered bits; bit_vld=0 from that point.
REQ-020 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in CLEAR, RUN, DONE.
REQ-022 Watchdog counter SHALL clear on each corr_vld_in in RUN; reaching TIMEOUT_CYCLES SHALL set err_timeout (sticky until next accepted start), flush buffer, enter DONE.
REQ-023 Counters SHALL not wrap; bit counter width LEN_WIDTH, watchdog width clog2(TIMEOUT_CYCLES+1).

Reset
REQ-024 rst SHALL force IDLE, empty buffer, clear counters, all outputs 0 on next clk edge, including mid-frame.
REQ-025 dec_rst SHALL NOT be asserted by rst; the decoder is reset by its own rst.

Configuration
REQ-026 With FM0_CTRL_TIMEOUT_EN defined, REQ-022 watchdog SHALL be present.
REQ-027 Without FM0_CTRL_TIMEOUT_EN, watchdog SHALL be absent, err_timeout tied 0, RUN exits only via REQ-019 or rst.

Structure
REQ-028 FSM state enum and state encodings SHALL live in shared package fm0_pkg.
REQ-029 Chunk buffer and serializer SHALL be sub-module fm0_chunk_ser; FSM, counters, watchdog in top.

Verification
REQ-030 start, frame_len=10, TRACEBACK_DEPTH=5, bit_rdy=1, chunks 5'b10110, 5'b00011 -> dec_rst 1 cycle, bits 0,1,1,0,1,1,1,0,0,0, done pulse after 10th transfer.
REQ-031 frame_len=3, chunk 5'b11111 -> exactly 3 bits, remaining 2 discarded, done=1, no overflow.
REQ-032 bit_rdy=0 held, 3 chunks arrive -> third dropped, err_overflow=1, bits of first two emitted once bit_rdy=1.
REQ-033 FM0_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no corr_vld_in for 16 cycles in RUN -> err_timeout=1, done=1, IDLE.
REQ-034 rst asserted mid-RUN after 4 bits -> next cycle busy=0, bit_vld=0, errors 0; new start restarts from bit 0.
REQ-035 frame_len=0 start -> CLEAR then DONE, no bit_vld, done pulse 2 cycles after start.

Source files
------------

// File: rtl/fm0_pkg.sv
// ---------------------------------------------------------------------------
// fm0_pkg
//   Shared definitions for the FM0 frame controller: the frame-control FSM
//   state type and its encodings.
// ---------------------------------------------------------------------------
package fm0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fm0_state_e;

endpackage

// File: rtl/fm0_chunk_ser.sv
// ---------------------------------------------------------------------------
// fm0_chunk_ser
//   Two-entry chunk buffer (active shift register + one pending chunk) that
//   serializes decoder chunks LSB first onto a valid/ready bit stream.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset (empties the buffer)
//   flush_i      discard all buffered bits this edge (wins over everything)
//   chunk_i      decoded chunk, bit 0 is emitted first
//   chunk_vld_i  chunk strobe (already qualified by the caller)
//   bit_rdy_i    downstream ready
//   bit_dat_o    serial data (0 while nothing is valid)
//   bit_vld_o    serial valid
//   bit_fire_o   a bit transfers at the coming edge
//   ovf_o        a chunk arrived with both entries occupied and was dropped
// ---------------------------------------------------------------------------
module fm0_chunk_ser
  import fm0_pkg::*;
#(
  parameter int TRACEBACK_DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [TRACEBACK_DEPTH-1:0] chunk_i,
  input  logic                       chunk_vld_i,
  input  logic                       bit_rdy_i,
  output logic                       bit_dat_o,
  output logic                       bit_vld_o,
  output logic                       bit_fire_o,
  output logic                       ovf_o
);

  localparam int CW = $clog2(TRACEBACK_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(TRACEBACK_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                       act_vld_q, act_vld_d;
  logic [CW-1:0]              act_cnt_q, act_cnt_d;
  logic [TRACEBACK_DEPTH-1:0] act_sh_q,  act_sh_d;
  logic                       pnd_vld_q, pnd_vld_d;
  logic [TRACEBACK_DEPTH-1:0] pnd_dat_q, pnd_dat_d;
  logic                       fire;

  assign fire       = act_vld_q & bit_rdy_i;
  assign bit_fire_o = fire;
  assign bit_vld_o  = act_vld_q;
  // Gate with valid so the unreset data register never leaks onto the port.
  assign bit_dat_o  = act_vld_q & act_sh_q[0];

  always_comb begin
    act_vld_d = act_vld_q;
    act_cnt_d = act_cnt_q;
    act_sh_d  = act_sh_q;
    pnd_vld_d = pnd_vld_q;
    pnd_dat_d = pnd_dat_q;
    ovf_o     = 1'b0;

    if (fire) begin
      if (act_cnt_q == CNT_ONE) begin
        act_vld_d = 1'b0;
      end else begin
        act_sh_d  = act_sh_q >> 1;
        act_cnt_d = act_cnt_q - CNT_ONE;
      end
    end

    // Refill the shifter from pending as soon as it drains, so a chunk that
    // arrives on the last-bit transfer lands in pending instead of dropping.
    if (!act_vld_d && pnd_vld_d) begin
      act_vld_d = 1'b1;
      act_sh_d  = pnd_dat_q;
      act_cnt_d = CNT_FULL;
      pnd_vld_d = 1'b0;
    end

    if (chunk_vld_i) begin
      if (!act_vld_d) begin
        act_vld_d = 1'b1;
        act_sh_d  = chunk_i;
        act_cnt_d = CNT_FULL;
      end else if (!pnd_vld_d) begin
        pnd_vld_d = 1'b1;
        pnd_dat_d = chunk_i;
      end else begin
        ovf_o = 1'b1;
      end
    end

    if (flush_i) begin
      act_vld_d = 1'b0;
      pnd_vld_d = 1'b0;
      ovf_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_vld_q <= 1'b0;
      act_cnt_q <= '0;
      pnd_vld_q <= 1'b0;
    end else begin
      act_vld_q <= act_vld_d;
      act_cnt_q <= act_cnt_d;
      pnd_vld_q <= pnd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    act_sh_q  <= act_sh_d;
    pnd_dat_q <= pnd_dat_d;
  end

endmodule

// File: rtl/fm0_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fm0_frame_ctrl
//   Frame controller sitting between an FM0 symbol correlator and a decoder.
//   It clears the decoder at frame start, gates correlator strobes to the
//   decoder while running, serializes decoded chunks into a bit stream and
//   ends the frame after the requested number of bit transfers.
//
//   Build option: define FM0_CTRL_TIMEOUT_EN to include the idle-symbol
//   watchdog; without it err_timeout is tied low and RUN only ends on the
//   bit count or reset.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          frame-start pulse (honoured in IDLE only)
//   frame_len      number of bits in the frame, sampled on accepted start
//   corr_vld_in    correlator symbol strobe
//   dec_vld        strobe forwarded to the decoder (RUN only)
//   dec_rst        one-cycle decoder metric clear at frame start
//   dec_dat        decoded chunk, dec_out_vld its strobe
//   bit_dat/bit_vld/bit_rdy  serial output stream
//   busy, done     frame in progress / one-cycle end-of-frame pulse
//   err_timeout    watchdog expired (sticky until next accepted start)
//   err_overflow   chunk dropped (sticky until next accepted start)
// ---------------------------------------------------------------------------
module fm0_frame_ctrl
  import fm0_pkg::*;
#(
  parameter int TRACEBACK_DEPTH = 5,
  parameter int LEN_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       frame_len,
  input  logic                       corr_vld_in,
  output logic                       dec_vld,
  output logic                       dec_rst,
  input  logic [TRACEBACK_DEPTH-1:0] dec_dat,
  input  logic                       dec_out_vld,
  output logic                       bit_dat,
  output logic                       bit_vld,
  input  logic                       bit_rdy,
  output logic                       busy,
  output logic                       done,
  output logic                       err_timeout,
  output logic                       err_overflow
);

  localparam logic [LEN_WIDTH:0]   CNT_ONE = (LEN_WIDTH+1)'(1);

  fm0_state_e           state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] bit_cnt_q;
  logic                 busy_q, done_q, dec_rst_q, err_ovf_q;
  logic                 in_run, bit_fire, ovf_pulse, last_xfer, wdog_hit, end_run;
  logic                 ser_flush;

`ifdef FM0_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wdog_q;
  logic            err_to_q;

  // Fires on the cycle whose edge would bring the idle count to the limit.
  assign wdog_hit    = in_run && !corr_vld_in && ((wdog_q + WD_W'(1)) == WD_LIMIT);
  assign err_timeout = err_to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wdog_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign in_run    = (state_q == ST_RUN);
  assign dec_vld   = in_run & corr_vld_in;
  assign last_xfer = (({1'b0, bit_cnt_q} + CNT_ONE) == {1'b0, len_q});
  assign end_run   = in_run && ((bit_fire && last_xfer) || wdog_hit);
  // Buffer is only live in RUN; leaving RUN discards whatever is still queued.
  assign ser_flush = !in_run || end_run;

  assign busy         = busy_q;
  assign done         = done_q;
  assign dec_rst      = dec_rst_q;
  assign err_overflow = err_ovf_q;

  fm0_chunk_ser #(
    .TRACEBACK_DEPTH (TRACEBACK_DEPTH)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (ser_flush),
    .chunk_i     (dec_dat),
    .chunk_vld_i (dec_out_vld & in_run),
    .bit_rdy_i   (bit_rdy),
    .bit_dat_o   (bit_dat),
    .bit_vld_o   (bit_vld),
    .bit_fire_o  (bit_fire),
    .ovf_o       (ovf_pulse)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) len_q <= frame_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dec_rst_q <= 1'b0;
      err_ovf_q <= 1'b0;
`ifdef FM0_CTRL_TIMEOUT_EN
      wdog_q    <= '0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      dec_rst_q <= 1'b0;
      if (ovf_pulse) err_ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_CLEAR;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            dec_rst_q <= 1'b1;
            err_ovf_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (len_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bit_fire) bit_cnt_q <= bit_cnt_q + LEN_WIDTH'(1);
          if (end_run) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

`ifdef FM0_CTRL_TIMEOUT_EN
      if (!in_run || corr_vld_in) wdog_q <= '0;
      else                        wdog_q <= wdog_q + WD_W'(1);
      if (state_q == ST_IDLE && start) err_to_q <= 1'b0;
      else if (wdog_hit)               err_to_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_fm0_frame_ctrl.sv
module tb_fm0_frame_ctrl;

  localparam int TD = 5;
  localparam int LW = 16;
  localparam int TO = 16;
`ifdef FM0_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst, start, corr_vld_in, dec_out_vld, bit_rdy;
  logic [LW-1:0] frame_len;
  logic [TD-1:0] dec_dat;
  logic          dec_vld, dec_rst, bit_dat, bit_vld, busy, done, err_timeout, err_overflow;

  fm0_frame_ctrl #(
    .TRACEBACK_DEPTH (TD),
    .LEN_WIDTH       (LW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_len    (frame_len),
    .corr_vld_in  (corr_vld_in),
    .dec_vld      (dec_vld),
    .dec_rst      (dec_rst),
    .dec_dat      (dec_dat),
    .dec_out_vld  (dec_out_vld),
    .bit_dat      (bit_dat),
    .bit_vld      (bit_vld),
    .bit_rdy      (bit_rdy),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: frame phase, bit queue holding every buffered bit.
  int m_phase = P_IDLE;
  int m_len = 0, m_cnt = 0, m_idle = 0;
  bit m_ovf = 1'b0, m_to = 1'b0, m_hit, m_end;
  bit m_q[$];

  // Observations for the literal checks.
  bit got_bits[$];
  int n_done = 0, n_decrst = 0, done_bits = 0;
  bit done_to = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_q.delete(); m_cnt = 0; m_idle = 0; m_ovf = 0; m_to = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_len = int'(frame_len); m_cnt = 0; m_ovf = 0; m_to = 0; m_phase = P_CLEAR;
        end
        P_CLEAR: begin
          m_idle = 0;
          m_phase = (m_len == 0) ? P_DONE : P_RUN;
        end
        P_RUN: begin
          m_hit = 1'b0;
          if (m_q.size() > 0 && bit_rdy) begin
            void'(m_q.pop_front());
            m_cnt++;
          end
          if (TO_EN) begin
            if (corr_vld_in) m_idle = 0; else m_idle++;
            m_hit = (m_idle == TO);
          end
          m_end = (m_cnt == m_len) || m_hit;
          if (m_end) begin
            m_q.delete();
            m_phase = P_DONE;
            if (m_hit) m_to = 1'b1;
          end else if (dec_out_vld) begin
            // Buffer holds at most two chunks; a partly drained one still counts.
            if ((m_q.size() + TD - 1) / TD < 2) begin
              for (int i = 0; i < TD; i++) m_q.push_back(dec_dat[i]);
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      bit ed;
      ev = (m_phase == P_RUN) && (m_q.size() > 0);
      ed = ev ? m_q[0] : 1'b0;
      chk("busy",         busy,         m_phase != P_IDLE);
      chk("done",         done,         m_phase == P_DONE);
      chk("dec_rst",      dec_rst,      m_phase == P_CLEAR);
      chk("dec_vld",      dec_vld,      (m_phase == P_RUN) && corr_vld_in);
      chk("bit_vld",      bit_vld,      ev);
      chk("bit_dat",      bit_dat,      ed);
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_timeout",  err_timeout,  m_to);
    end
    if (!rst && bit_vld && bit_rdy) got_bits.push_back(bit_dat);
    if (done) begin
      n_done++;
      done_bits = got_bits.size();
      done_to = err_timeout;
    end
    if (dec_rst) n_decrst++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    frame_len = LW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [TD-1:0] c);
    dec_dat = c;
    dec_out_vld = 1'b1;
    tick();
    dec_out_vld = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (n_done == base && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", n_done > base, 1);
  endtask

  task automatic chk_bits(input string nm, input int n, input logic [31:0] exp);
    logic [31:0] v;
    v = '0;
    chk({nm, "_count"}, got_bits.size(), n);
    for (int i = 0; i < got_bits.size() && i < 32; i++) v[i] = got_bits[i];
    chk(nm, v, exp);
  endtask

  initial begin
    int base, dbase, k;
    rst = 1'b1; start = 1'b0; frame_len = '0; corr_vld_in = 1'b1;
    dec_dat = '0; dec_out_vld = 1'b0; bit_rdy = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_bit_vld", bit_vld, 0);

    // Two chunks, ten bits, full-rate ready.
    got_bits.delete(); base = n_done; dbase = n_decrst;
    do_start(10);
    tick();
    send_chunk(5'b10110);
    tick(); tick();
    send_chunk(5'b00011);
    wait_done(base, 40);
    chk_bits("bits_10", 10, 32'b0001110110);
    chk("done_after_10th", done_bits, 10);
    chk("dec_rst_cycles", n_decrst - dbase, 1);
    tick(); tick();

    // Short frame: trailing bits of the chunk are discarded.
    got_bits.delete(); base = n_done;
    do_start(3);
    tick();
    send_chunk(5'b11111);
    wait_done(base, 20);
    chk_bits("bits_3", 3, 32'b111);
    chk("no_ovf_short", err_overflow, 0);
    tick(); tick();

    // Back-pressure: third chunk dropped, first two delivered later.
    got_bits.delete(); base = n_done;
    bit_rdy = 1'b0;
    do_start(10);
    tick();
    send_chunk(5'b10011);
    send_chunk(5'b01100);
    send_chunk(5'b11111);
    tick(); tick();
    chk("ovf_set", err_overflow, 1);
    chk("hold_vld", bit_vld, 1);
    bit_rdy = 1'b1;
    wait_done(base, 40);
    chk_bits("bits_bp", 10, 32'b0110010011);
    tick();
    chk("ovf_sticky", err_overflow, 1);
    tick();

    // Toggling ready with a chunk landing in pending mid-stream.
    got_bits.delete(); base = n_done;
    do_start(7);
    tick();
    send_chunk(5'b01101);
    for (int i = 0; i < 30; i++) begin
      bit_rdy = (i % 3 != 1);
      if (i == 2) begin
        dec_dat = 5'b10010;
        dec_out_vld = 1'b1;
      end else begin
        dec_out_vld = 1'b0;
      end
      tick();
    end
    dec_out_vld = 1'b0;
    bit_rdy = 1'b1;
    chk("toggle_done_count", n_done - base, 1);
    chk_bits("bits_toggle", 7, 32'b1001101);
    chk("ovf_cleared_by_start", err_overflow, 0);

    // Reset mid-frame after four transfers, then a clean restart.
    got_bits.delete();
    do_start(20);
    tick();
    send_chunk(5'b10101);
    send_chunk(5'b11001);
    k = 0;
    while (got_bits.size() < 4 && k < 20) begin
      tick();
      k++;
    end
    chk("four_bits_seen", got_bits.size(), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_bit_vld", bit_vld, 0);
    chk("midrst_ovf", err_overflow, 0);
    chk("midrst_to", err_timeout, 0);
    tick();
    got_bits.delete(); base = n_done;
    do_start(5);
    tick();
    send_chunk(5'b10110);
    wait_done(base, 20);
    chk_bits("bits_restart", 5, 32'b10110);
    tick();

    // Zero-length frame: CLEAR then DONE, no bits.
    got_bits.delete();
    do_start(0);
    @(negedge clk);
    chk("len0_dec_rst", dec_rst, 1);
    chk("len0_no_done_yet", done, 0);
    tick();
    @(negedge clk);
    chk("len0_done", done, 1);
    tick();
    @(negedge clk);
    chk("len0_idle", busy, 0);
    chk("len0_no_bits", got_bits.size(), 0);
    tick();

    if (TO_EN) begin
      // Silent correlator: watchdog ends the frame.
      got_bits.delete(); base = n_done;
      corr_vld_in = 1'b0;
      do_start(10);
      tick();
      send_chunk(5'b10101);
      wait_done(base, 40);
      chk("timeout_flag", done_to, 1);
      chk_bits("bits_timeout", 5, 32'b10101);
      tick();
      chk("timeout_idle", busy, 0);
      corr_vld_in = 1'b1;
      do_start(0);
      tick();
      chk("timeout_cleared", err_timeout, 0);
      tick(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
